// File: rtl/nios_setup_v2_led_pio_pkg.sv
// Shared constants for the LED output PIO: register word addresses and STATUS bit positions.
package nios_setup_v2_led_pio_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_MASK     = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_STATUS   = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;

    localparam int STATUS_PHASE_BIT  = 0;
    localparam int STATUS_ACTIVE_BIT = 1;

endpackage

// File: rtl/nios_setup_v2_led_pio_if.sv
// Avalon-MM slave bus bundle for the LED PIO.
// Handshake: a transfer happens at any clk edge where chipselect=1; write_n=0 marks a
// write, read=1 marks a read. There is no waitrequest, so every selected access completes
// at that edge, and read data is presented on readdata one cycle after the read strobe.
interface nios_setup_v2_led_pio_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic        read;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, read, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, read, writedata,
        output readdata
    );
endinterface

// File: rtl/nios_setup_v2_blink_timer.sv
// Half-period blink timer: counts clk cycles and toggles phase every PERIOD cycles.
// A zero period parks the timer with phase low; a period write restarts it from zero.
module nios_setup_v2_blink_timer #(
    parameter int PERIOD_W = 24
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [PERIOD_W-1:0] period,
    input  logic                period_wr,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt_q;

    // Counter and phase; a period write wins over the terminal-count toggle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_q <= '0;
            phase <= 1'b0;
        end else if (period_wr || (period == '0)) begin
            cnt_q <= '0;
            phase <= 1'b0;
        end else if (cnt_q == (period - 1'b1)) begin
            cnt_q <= '0;
            phase <= ~phase;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/nios_setup_v2_led_pio.sv
// LED output PIO on the Nios II data bus: DATA register with atomic set/clear, and
// (with LED_PIO_BLINK_EN defined) a per-bit blink mask gated by a half-period timer.
// Without LED_PIO_BLINK_EN, MASK/PERIOD/STATUS read as zero and out_port follows DATA.
module nios_setup_v2_led_pio
    import nios_setup_v2_led_pio_pkg::*;
#(
    parameter int          DATA_W      = 8,
    parameter int          PERIOD_W    = 24,
    parameter logic [31:0] RESET_VALUE = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    nios_setup_v2_led_pio_if.slave   bus,
    output logic [DATA_W-1:0]        out_port
);

    logic              wr_en;
    logic              rd_en;
    logic [DATA_W-1:0] wr_val;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] data_d;
    logic [DATA_W-1:0] out_d;
    logic [31:0]       rd_val;
    logic              unused_bits;

    assign wr_en  = bus.chipselect && !bus.write_n;
    assign rd_en  = bus.chipselect && bus.read;
    assign wr_val = bus.writedata[DATA_W-1:0];

    // Next DATA value: plain write, OR-in set, or AND-out clear.
    always_comb begin
        data_d = data_q;
        if (wr_en) begin
            case (bus.address)
                ADDR_DATA:     data_d = wr_val;
                ADDR_OUTSET:   data_d = data_q | wr_val;
                ADDR_OUTCLEAR: data_d = data_q & ~wr_val;
                default:       data_d = data_q;
            endcase
        end
    end

    // DATA register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data_q <= RESET_VALUE[DATA_W-1:0];
        end else begin
            data_q <= data_d;
        end
    end

`ifdef LED_PIO_BLINK_EN
    logic [DATA_W-1:0]   mask_q;
    logic [PERIOD_W-1:0] period_q;
    logic                period_wr;
    logic                phase;

    assign period_wr = wr_en && (bus.address == ADDR_PERIOD);

    // MASK and PERIOD registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_q   <= '0;
            period_q <= '0;
        end else if (wr_en) begin
            if (bus.address == ADDR_MASK) begin
                mask_q <= wr_val;
            end
            if (bus.address == ADDR_PERIOD) begin
                period_q <= bus.writedata[PERIOD_W-1:0];
            end
        end
    end

    nios_setup_v2_blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .period    (period_q),
        .period_wr (period_wr),
        .phase     (phase)
    );

    // Masked bits follow DATA only while phase is high; unmasked bits follow DATA.
    always_comb begin
        out_d = (data_q & ~mask_q) | (data_q & mask_q & {DATA_W{phase}});
    end

    // Register read mux, zero-extended to the bus width.
    always_comb begin
        rd_val = '0;
        case (bus.address)
            ADDR_DATA:   rd_val[DATA_W-1:0]   = data_q;
            ADDR_MASK:   rd_val[DATA_W-1:0]   = mask_q;
            ADDR_PERIOD: rd_val[PERIOD_W-1:0] = period_q;
            ADDR_STATUS: begin
                rd_val[STATUS_PHASE_BIT]  = phase;
                rd_val[STATUS_ACTIVE_BIT] = (period_q != '0);
            end
            default:     rd_val = '0;
        endcase
    end
`else
    // No blink hardware: LEDs mirror DATA.
    always_comb begin
        out_d = data_q;
    end

    // Register read mux; only DATA is readable in this build.
    always_comb begin
        rd_val = '0;
        if (bus.address == ADDR_DATA) begin
            rd_val[DATA_W-1:0] = data_q;
        end
    end
`endif

    // Upper writedata bits are intentionally dropped.
    assign unused_bits = ^bus.writedata ^ (PERIOD_W > 0 ? 1'b0 : 1'b1);

    // Registered LED drive, one cycle behind the registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            out_port <= RESET_VALUE[DATA_W-1:0];
        end else begin
            out_port <= out_d;
        end
    end

    // Registered read data; holds between reads.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.readdata <= '0;
        end else if (rd_en) begin
            bus.readdata <= rd_val;
        end
    end

endmodule
